// File: rtl/glb_fill_ctrl.sv
// ---------------------------------------------------------------------------
// glb_fill_ctrl
// Write-side fill engine for the banked global buffer. One command (base row,
// word count) is taken in IDLE. The following valid/ready word stream is then
// scattered round-robin over the banks:
//   stream word k -> bank (k mod BANK_NUM), row (base + k div BANK_NUM) mod BANK_DEPTH
// The per-bank write ports of the buffer are driven directly, one cycle after
// each accepted word.
//
// Ports
//   i_clk, i_rst   clock (rising edge) / asynchronous active-high reset
//   i_start        command strobe, only looked at in IDLE
//   i_base_addr    starting row used in every bank
//   i_len          number of words to write (0 = empty command)
//   i_valid/i_data stream word and its valid flag
//   o_ready        stream ready, high for the whole FILL state
//   o_we/o_wa/o_wd per-bank write enable / row address / data
//   o_busy         high in FILL and DONE
//   o_done         one-cycle pulse, coincident with the last write pulse
// ---------------------------------------------------------------------------
module glb_fill_ctrl #(
  parameter int DATA_BITWIDTH = 32,
  parameter int BANK_NUM      = 32,
  parameter int BANK_DEPTH    = 1024,
  parameter int LEN_W         = 16,
  localparam int ADDR_W       = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_start,
  input  logic [ADDR_W-1:0]                       i_base_addr,
  input  logic [LEN_W-1:0]                        i_len,
  input  logic                                    i_valid,
  input  logic [DATA_BITWIDTH-1:0]                i_data,
  output logic                                    o_ready,
  output logic [BANK_NUM-1:0]                     o_we,
  output logic [BANK_NUM-1:0][ADDR_W-1:0]         o_wa,
  output logic [BANK_NUM-1:0][DATA_BITWIDTH-1:0]  o_wd,
  output logic                                    o_busy,
  output logic                                    o_done
);

  localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   bank_q,  bank_d;
  logic [ADDR_W-1:0]   row_q,   row_d;
  logic [LEN_W-1:0]    rem_q,   rem_d;
  logic                accept;

  // o_ready is a pure decode of the state register, so it is glitch-free and
  // drops on the edge that accepts the last word.
  assign o_ready = (state_q == ST_FILL);
  assign accept  = i_valid && o_ready;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = (state_q == ST_DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      row_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            state_d = ST_FILL;
            bank_d  = '0;
            row_d   = i_base_addr;
            rem_d   = i_len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FILL: begin
        if (accept) begin
          rem_d = rem_q - 1'b1;
          // Bank pointer wraps by compare (BANK_NUM need not be a power of
          // two); the row advances only when a full sweep of banks completes.
          if (bank_q == BANK_W'(BANK_NUM - 1)) begin
            bank_d = '0;
            row_d  = (row_q == ADDR_W'(BANK_DEPTH - 1)) ? '0 : row_q + 1'b1;
          end else begin
            bank_d = bank_q + 1'b1;
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-bank write port registers. Each bank only captures address/data when
  // it is the target of the current accept, so non-written banks hold.
  genvar gi;
  generate
    for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
      logic                     hit;
      logic                     we_q;
      logic [ADDR_W-1:0]        wa_q, wa_d;
      logic [DATA_BITWIDTH-1:0] wd_q, wd_d;

      assign hit  = accept && (bank_q == BANK_W'(gi));
      assign wa_d = hit ? row_q  : wa_q;
      assign wd_d = hit ? i_data : wd_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          we_q <= 1'b0;
          wa_q <= '0;
          wd_q <= '0;
        end else begin
          we_q <= hit;
          wa_q <= wa_d;
          wd_q <= wd_d;
        end
      end

      assign o_we[gi] = we_q;
      assign o_wa[gi] = wa_q;
      assign o_wd[gi] = wd_q;
    end
  endgenerate

endmodule

// File: tb/tb_glb_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_glb_fill_ctrl
// Directed plus randomized fills of a 4-bank, 16-row configuration. Expected
// writes come from the address formula (bank = k mod 4, row = (base + k/4)
// mod 16) and a shadow copy of every bank's last written address/data.
// ---------------------------------------------------------------------------
module tb_glb_fill_ctrl;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int ND = 16;
  localparam int LW = 16;
  localparam int AW = 4;

  logic                    clk;
  logic                    i_rst;
  logic                    i_start;
  logic [AW-1:0]           i_base_addr;
  logic [LW-1:0]           i_len;
  logic                    i_valid;
  logic [DW-1:0]           i_data;
  logic                    o_ready;
  logic [NB-1:0]           o_we;
  logic [NB-1:0][AW-1:0]   o_wa;
  logic [NB-1:0][DW-1:0]   o_wd;
  logic                    o_busy;
  logic                    o_done;

  int checks = 0;
  int errors = 0;

  // Shadow of the last address/data written to each bank.
  logic [AW-1:0] exp_wa [NB];
  logic [DW-1:0] exp_wd [NB];

  glb_fill_ctrl #(
    .DATA_BITWIDTH(DW),
    .BANK_NUM     (NB),
    .BANK_DEPTH   (ND),
    .LEN_W        (LW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_we        (o_we),
    .o_wa        (o_wa),
    .o_wd        (o_wd),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [NB-1:0] we, input logic rdy,
                           input logic busy, input logic done);
    logic [NB*AW-1:0] pa;
    logic [NB*DW-1:0] pd;
    for (int b = 0; b < NB; b++) begin
      pa[b*AW +: AW] = exp_wa[b];
      pd[b*DW +: DW] = exp_wd[b];
    end
    check("o_we",    128'(o_we),    128'(we));
    check("o_ready", 128'(o_ready), 128'(rdy));
    check("o_busy",  128'(o_busy),  128'(busy));
    check("o_done",  128'(o_done),  128'(done));
    check("o_wa",    128'(o_wa),    128'(pa));
    check("o_wd",    128'(o_wd),    128'(pd));
  endtask

  task automatic clear_model();
    for (int b = 0; b < NB; b++) begin
      exp_wa[b] = '0;
      exp_wd[b] = '0;
    end
  endtask

  // mode 0: continuous valid, 1: alternating valid, 2: random valid/data.
  // abort_after > 0 asserts reset mid-cycle once that many words are accepted.
  task automatic run_fill(input int base, input int len, input int mode, input int abort_after);
    int k;
    int edges;
    int b;
    logic v;
    logic [DW-1:0] d;
    k = 0;
    edges = 0;
    i_start = 1'b1;
    i_base_addr = AW'(base);
    i_len = LW'(len);
    @(posedge clk); #1;
    i_start = 1'b0;
    i_base_addr = AW'($urandom);
    i_len = LW'($urandom);
    if (len == 0) begin
      check_all('0, 1'b0, 1'b1, 1'b1);
    end else begin
      check_all('0, 1'b1, 1'b1, 1'b0);
      while (k < len) begin
        if (edges > 200) begin
          check("fill_timeout", 128'(k), 128'(len));
          break;
        end
        case (mode)
          0:       v = 1'b1;
          1:       v = (edges % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        d = (mode == 2) ? DW'($urandom) : DW'(32'hA0 + k);
        i_valid = v;
        i_data  = d;
        // Starts issued while busy must be ignored.
        i_start = ($urandom_range(0, 3) == 0);
        i_len   = LW'($urandom);
        if (abort_after > 0 && k == abort_after) begin
          #2 i_rst = 1'b1;
          clear_model();
          #1 check_all('0, 1'b0, 1'b0, 1'b0);
          #2 i_rst = 1'b0;
          i_start = 1'b0;
          @(posedge clk); #1;
          check_all('0, 1'b0, 1'b0, 1'b0);
          i_valid = 1'b0;
          $display("fill base=%0d len=%0d aborted by reset after %0d words", base, len, k);
          return;
        end
        @(posedge clk); #1;
        edges++;
        if (v) begin
          b = k % NB;
          exp_wa[b] = AW'((base + k / NB) % ND);
          exp_wd[b] = d;
          k++;
          check_all(NB'(1 << b), (k < len), 1'b1, (k == len));
        end else begin
          check_all('0, 1'b1, 1'b1, 1'b0);
        end
      end
      if (mode == 0) check("latency", 128'(edges), 128'(len));
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    @(posedge clk); #1;
    check_all('0, 1'b0, 1'b0, 1'b0);
    $display("fill base=%0d len=%0d mode=%0d complete after %0d accept cycles", base, len, mode, edges);
  endtask

  initial begin
    clear_model();
    i_rst = 1'b1;
    i_start = 1'b0;
    i_base_addr = '0;
    i_len = '0;
    i_valid = 1'b0;
    i_data = '0;
    #1 check_all('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk); #1;
    check_all('0, 1'b0, 1'b0, 1'b0);

    run_fill(2, 6, 0, 0);    // continuous A0..A5
    run_fill(2, 6, 1, 0);    // stalled stream, same writes
    run_fill(15, 8, 0, 0);   // row wrap 15 -> 0
    run_fill(3, 0, 0, 0);    // empty command
    run_fill(2, 6, 0, 3);    // reset mid-fill
    run_fill(2, 6, 0, 0);    // fresh fill after abort
    for (int t = 0; t < 20; t++) begin
      run_fill(int'($urandom_range(0, ND - 1)), int'($urandom_range(0, 20)),
               int'($urandom_range(0, 2)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
